// File: rtl/lut_wvf_pkg.sv
// -----------------------------------------------------------------------------
// lut_wvf_pkg
// Shared types for the LUT waveform generator: FSM state encoding, quadrant
// encoding used by the quarter-wave address mapper, and the width of the
// per-channel step index (which spans four quarter-wave quadrants).
// -----------------------------------------------------------------------------
package lut_wvf_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Quadrant of a quarter-wave index: bit 0 mirrors the address,
   // bit 1 negates the sample.
   typedef enum logic [1:0] {
      QUAD_0 = 2'd0,
      QUAD_1 = 2'd1,
      QUAD_2 = 2'd2,
      QUAD_3 = 2'd3
   } quad_e;

   // Index width covering 4*LUT_DEPTH positions (a full quarter-wave period).
   function automatic int idx_width(input int lut_depth);
      return $clog2(4 * lut_depth);
   endfunction

endpackage

// File: rtl/lut_wvf_addr_map.sv
// -----------------------------------------------------------------------------
// lut_wvf_addr_map
// Maps one channel's step index to a ROM address and a negate flag.
// Full-period mode uses the low address bits directly; quarter-wave mode
// mirrors the address in odd quadrants and negates in the second half period.
//
// Ports:
//   mode_qw_i  1 = quarter-wave ROM, 0 = full-period ROM
//   idx_i      channel index, already reduced modulo the period
//   addr_o     ROM entry to read
//   neg_o      1 = sample must be negated
// -----------------------------------------------------------------------------
module lut_wvf_addr_map
   import lut_wvf_pkg::*;
#(
   parameter  int LUT_DEPTH = 32,
   localparam int IW        = idx_width(LUT_DEPTH),
   localparam int AW        = $clog2(LUT_DEPTH)
) (
   input  logic          mode_qw_i,
   input  logic [IW-1:0] idx_i,
   output logic [AW-1:0] addr_o,
   output logic          neg_o
);

   logic [AW-1:0] r;
   quad_e         q;

   assign r = idx_i[AW-1:0];
   assign q = quad_e'(idx_i[IW-1:AW]);

   // LUT_DEPTH is a power of two, so LUT_DEPTH-1-r is just ~r.
   always_comb begin
      // NOTE: defaults are assigned first so every path drives every output; no latch can be inferred.
      addr_o = r;
      neg_o  = 1'b0;
      if (mode_qw_i) begin
         case (q)
            QUAD_0: ;
            QUAD_1: addr_o = ~r;
            QUAD_2: neg_o  = 1'b1;
            QUAD_3: begin
               addr_o = ~r;
               neg_o  = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/lut_wvf_gen_mc.sv
// -----------------------------------------------------------------------------
// lut_wvf_gen_mc
// Multi-channel waveform generator reading one shared sample ROM. A base index
// k steps through one period (internal interval counter or external trigger
// edges); each channel adds its own phase offset and presents a registered
// sample with a one-cycle LUT_VALID pulse. Optional single-shot operation.
//
// Ports:
//   CLK_SYS, RST      clock, asynchronous active-high reset
//   EN                run enable (IDLE <-> RUN)
//   MODE_QW           1 = quarter-wave ROM (period 4*LUT_DEPTH), 0 = full ROM
//   SHOT              1 = stop after one period
//   TRG_EXT           1 = step on TRGG_CNT_FLAG rising edges, 0 = every WAIT_CYC
//   WAIT_CYC          cycles per internal step (0 behaves as 1)
//   TRGG_CNT_FLAG     external step request, synchronous to CLK_SYS
//   PHASE_OFS         per-channel index offsets, channel 0 in the LSBs
//   LUT_ROM           packed sample table, entry 0 in the LSBs
//   LUT_VALUE         per-channel samples, channel 0 in the LSBs
//   LUT_VALID         one-cycle pulse with each new LUT_VALUE
//   LUT_END           one-cycle pulse with the sample for k = P-1
//   BUSY              high while running
// Mode, shot, trigger source, interval and offsets are captured on entry to RUN.
// -----------------------------------------------------------------------------
module lut_wvf_gen_mc
   import lut_wvf_pkg::*;
#(
   parameter  int BITWIDTH   = 8,
   parameter  int LUT_DEPTH  = 32,
   parameter  int NUM_CH     = 2,
   parameter  int WAIT_WIDTH = 16,
   localparam int IW         = idx_width(LUT_DEPTH)
) (
   input  logic                         CLK_SYS,
   input  logic                         RST,
   input  logic                         EN,
   input  logic                         MODE_QW,
   input  logic                         SHOT,
   input  logic                         TRG_EXT,
   input  logic [WAIT_WIDTH-1:0]        WAIT_CYC,
   input  logic                         TRGG_CNT_FLAG,
   input  logic [NUM_CH*IW-1:0]         PHASE_OFS,
   input  logic [LUT_DEPTH*BITWIDTH-1:0] LUT_ROM,
   output logic [NUM_CH*BITWIDTH-1:0]   LUT_VALUE,
   output logic                         LUT_VALID,
   output logic                         LUT_END,
   output logic                         BUSY
);

   localparam int                  AW        = $clog2(LUT_DEPTH);
   localparam logic [IW-1:0]       LAST_FULL = IW'(LUT_DEPTH - 1);
   localparam logic [IW-1:0]       LAST_QW   = IW'(4 * LUT_DEPTH - 1);
   localparam logic [BITWIDTH-1:0] S_MIN     = {1'b1, {(BITWIDTH-1){1'b0}}};
   localparam logic [BITWIDTH-1:0] S_MAX     = ~S_MIN;

   state_e                       state_q, state_d;
   logic [IW-1:0]                k_q, k_d;
   logic [WAIT_WIDTH-1:0]        wcnt_q, wcnt_d;
   logic                         trg_q;
   // Set when a single-shot period completes; blocks re-entry until EN drops.
   logic                         done_q, done_d;
   logic [NUM_CH*BITWIDTH-1:0]   value_q, value_d;
   logic                         valid_q, valid_d;
   logic                         end_q, end_d;
   logic                         load_cfg;

   // Configuration captured on IDLE->RUN.
   logic                         mode_q, shot_q, ext_q;
   logic [WAIT_WIDTH-1:0]        wait_q;
   logic [NUM_CH*IW-1:0]         ofs_q;

   logic [WAIT_WIDTH-1:0]        wait_eff;
   logic [IW-1:0]                last_k;
   logic                         at_last, int_step, ext_step, step;
   logic [NUM_CH*BITWIDTH-1:0]   samples;
   logic [BITWIDTH-1:0]          rom [LUT_DEPTH];

   assign wait_eff = (wait_q == '0) ? WAIT_WIDTH'(1) : wait_q;
   assign int_step = (wcnt_q == wait_eff - WAIT_WIDTH'(1));
   assign ext_step = TRGG_CNT_FLAG & ~trg_q;
   assign step     = ext_q ? ext_step : int_step;
   assign last_k   = mode_q ? LAST_QW : LAST_FULL;
   assign at_last  = (k_q == last_k);

   for (genvar e = 0; e < LUT_DEPTH; e++) begin : g_rom
      assign rom[e] = LUT_ROM[e*BITWIDTH +: BITWIDTH];
   end

   // The IW-bit sum wraps modulo 4*LUT_DEPTH; full mode keeps only the low
   // address bits inside the mapper, which gives the modulo-LUT_DEPTH index.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [IW-1:0]       idx;
      logic [AW-1:0]       addr;
      logic                neg;
      logic [BITWIDTH-1:0] raw;

      assign idx = k_q + ofs_q[c*IW +: IW];

      lut_wvf_addr_map #(.LUT_DEPTH(LUT_DEPTH)) u_map (
         .mode_qw_i (mode_q),
         .idx_i     (idx),
         .addr_o    (addr),
         .neg_o     (neg)
      );

      assign raw = rom[addr];
      // The most negative code has no positive twin; clamp it to full scale.
      assign samples[c*BITWIDTH +: BITWIDTH] =
         !neg           ? raw   :
         (raw == S_MIN) ? S_MAX : (~raw + BITWIDTH'(1));
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      wcnt_d   = wcnt_q;
      done_d   = done_q;
      value_d  = value_q;
      valid_d  = 1'b0;
      end_d    = 1'b0;
      load_cfg = 1'b0;

      case (state_q)
         ST_IDLE: begin
            k_d    = '0;
            wcnt_d = '0;
            if (!EN) begin
               done_d = 1'b0;
            end else if (!done_q) begin
               state_d  = ST_RUN;
               load_cfg = 1'b1;
            end
         end

         ST_RUN: begin
            // Dropping EN wins over a step in the same cycle.
            if (!EN) begin
               state_d = ST_IDLE;
               k_d     = '0;
               wcnt_d  = '0;
            end else begin
               if (!ext_q) begin
                  wcnt_d = int_step ? '0 : wcnt_q + WAIT_WIDTH'(1);
               end
               if (step) begin
                  value_d = samples;
                  valid_d = 1'b1;
                  end_d   = at_last;
                  k_d     = at_last ? '0 : k_q + IW'(1);
                  if (at_last && shot_q) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_SYS or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         wcnt_q  <= '0;
         trg_q   <= 1'b0;
         done_q  <= 1'b0;
         value_q <= '0;
         valid_q <= 1'b0;
         end_q   <= 1'b0;
         mode_q  <= 1'b0;
         shot_q  <= 1'b0;
         ext_q   <= 1'b0;
         wait_q  <= '0;
         ofs_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         state_q <= state_d;
         k_q     <= k_d;
         wcnt_q  <= wcnt_d;
         trg_q   <= TRGG_CNT_FLAG;
         done_q  <= done_d;
         value_q <= value_d;
         valid_q <= valid_d;
         end_q   <= end_d;
         if (load_cfg) begin
            mode_q <= MODE_QW;
            shot_q <= SHOT;
            ext_q  <= TRG_EXT;
            wait_q <= WAIT_CYC;
            ofs_q  <= PHASE_OFS;
         end
      end
   end

   assign LUT_VALUE = value_q;
   assign LUT_VALID = valid_q;
   assign LUT_END   = end_q;
   assign BUSY      = (state_q == ST_RUN);

endmodule
